// File: rtl/bubble_unsort.sv
// rtl/bubble_unsort.sv - scatters five sorted, origin-tagged words back to their original slots, one per cycle
// Optional build macro PERM_CHECK_EN: first-write-wins duplicate guard with a sticky err flag.
module bubble_unsort #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] s1,
    input  logic [DATA_W-1:0] s2,
    input  logic [DATA_W-1:0] s3,
    input  logic [DATA_W-1:0] s4,
    input  logic [DATA_W-1:0] s5,
    input  logic [2:0]        t1,
    input  logic [2:0]        t2,
    input  logic [2:0]        t3,
    input  logic [2:0]        t4,
    input  logic [2:0]        t5,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, SCATTER, DONE} state_t;

    state_t            state;
    logic [2:0]        j;
    logic [DATA_W-1:0] s_reg [5];
    logic [2:0]        t_reg [5];
    logic [DATA_W-1:0] o_reg [5];

    logic [DATA_W-1:0] cur_s;
    logic [2:0]        cur_t;
    logic [2:0]        slot;
    logic              tag_ok;
    logic [4:0]        slot_hot;
    logic [4:0]        wr_hot;

    always_comb begin
        cur_s = '0;
        cur_t = 3'd0;
        case (j)
            3'd1: begin cur_s = s_reg[0]; cur_t = t_reg[0]; end
            3'd2: begin cur_s = s_reg[1]; cur_t = t_reg[1]; end
            3'd3: begin cur_s = s_reg[2]; cur_t = t_reg[2]; end
            3'd4: begin cur_s = s_reg[3]; cur_t = t_reg[3]; end
            3'd5: begin cur_s = s_reg[4]; cur_t = t_reg[4]; end
            default: ;
        endcase
    end

    assign tag_ok   = (cur_t >= 3'd1) && (cur_t <= 3'd5);
    assign slot     = cur_t - 3'd1;
    assign slot_hot = tag_ok ? (5'b00001 << slot) : 5'b00000;

`ifdef PERM_CHECK_EN
    logic [4:0] seen;
    logic       err_acc;
    logic       bad_now;

    // A slot already claimed by a lower rank keeps its word; the later claimant only raises err.
    assign bad_now = !tag_ok || ((seen & slot_hot) != 5'b00000);
    assign wr_hot  = bad_now ? 5'b00000 : slot_hot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen    <= 5'b00000;
            err_acc <= 1'b0;
            err     <= 1'b0;
        end else if (state == IDLE && in_valid && in_ready) begin
            seen    <= 5'b00000;
            err_acc <= 1'b0;
            err     <= 1'b0;
        end else if (state == SCATTER) begin
            seen <= seen | wr_hot;
            if (bad_now)
                err_acc <= 1'b1;
            if (j == 3'd5)
                err <= err_acc | bad_now;
        end
    end
`else
    assign wr_hot = slot_hot;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            j         <= 3'd1;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                s_reg[i] <= '0;
                t_reg[i] <= 3'd0;
                o_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        s_reg[0] <= s1;
                        s_reg[1] <= s2;
                        s_reg[2] <= s3;
                        s_reg[3] <= s4;
                        s_reg[4] <= s5;
                        t_reg[0] <= t1;
                        t_reg[1] <= t2;
                        t_reg[2] <= t3;
                        t_reg[3] <= t4;
                        t_reg[4] <= t5;
                        for (int i = 0; i < 5; i++)
                            o_reg[i] <= '0;
                        j        <= 3'd1;
                        in_ready <= 1'b0;
                        state    <= SCATTER;
                    end
                end
                SCATTER: begin
                    for (int i = 0; i < 5; i++)
                        if (wr_hot[i])
                            o_reg[i] <= cur_s;
                    if (j == 3'd5) begin
                        j         <= 3'd1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        j <= j + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out1 = o_reg[0];
    assign out2 = o_reg[1];
    assign out3 = o_reg[2];
    assign out4 = o_reg[3];
    assign out5 = o_reg[4];

endmodule

// File: tb/tb_bubble_unsort.sv
// tb/tb_bubble_unsort.sv - directed self-checking bench for bubble_unsort
module tb_bubble_unsort;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] s1, s2, s3, s4, s5;
    logic [2:0]  t1, t2, t3, t4, t5;
    logic [15:0] out1, out2, out3, out4, out5;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PERM_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    bubble_unsort #(.DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
        .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [15:0] e1, e2, e3, e4, e5,
                              input logic e_err);
        check_val({tag, "_o1"}, 32'(out1), 32'(e1));
        check_val({tag, "_o2"}, 32'(out2), 32'(e2));
        check_val({tag, "_o3"}, 32'(out3), 32'(e3));
        check_val({tag, "_o4"}, 32'(out4), 32'(e4));
        check_val({tag, "_o5"}, 32'(out5), 32'(e5));
        check_val({tag, "_err"}, 32'(err), 32'(e_err));
    endtask

    task automatic put_frame(input logic [15:0] a, b, c, d, e,
                             input logic [2:0] ta, tb, tc, td, te);
        int n;
        s1 = a; s2 = b; s3 = c; s4 = d; s5 = e;
        t1 = ta; t2 = tb; t3 = tc; t4 = td; t5 = te;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready)
            check_val("accept_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        // Scramble inputs after the accept edge: the frame must already be captured.
        s1 = 16'hdead; s2 = 16'hdead; s3 = 16'hdead; s4 = 16'hdead; s5 = 16'hdead;
        t1 = 3'd0; t2 = 3'd0; t3 = 3'd0; t4 = 3'd0; t5 = 3'd0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid)
            check_val("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val({tag, "_hs_ov"}, 32'(out_valid), 32'd0);
        check_val({tag, "_hs_ir"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int gap;
        logic seen_a;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        s1 = 0; s2 = 0; s3 = 0; s4 = 0; s5 = 0;
        t1 = 0; t2 = 0; t3 = 0; t4 = 0; t5 = 0;
        step();
        step();
        rst_n = 1'b1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_outs("rst", 0, 0, 0, 0, 0, 1'b0);

        // Identity permutation.
        put_frame(10, 20, 30, 40, 50, 1, 2, 3, 4, 5);
        check_val("id_in_ready_busy", 32'(in_ready), 32'd0);
        wait_out(lat);
        check_val("id_latency", 32'(lat), 32'd5);
        check_outs("id", 10, 20, 30, 40, 50, 1'b0);
        handshake("id");

        // Reverse permutation with downstream stall.
        put_frame(1, 2, 3, 4, 5, 5, 4, 3, 2, 1);
        wait_out(lat);
        check_val("rev_latency", 32'(lat), 32'd5);
        check_outs("rev", 5, 4, 3, 2, 1, 1'b0);
        in_valid = 1'b1;
        s1 = 16'd77; t1 = 3'd1;
        for (int k = 0; k < 3; k++) step();
        check_val("rev_stall_ov", 32'(out_valid), 32'd1);
        check_val("rev_stall_ir", 32'(in_ready), 32'd0);
        check_outs("rev_stall", 5, 4, 3, 2, 1, 1'b0);
        in_valid = 1'b0;
        handshake("rev");

        // Duplicate tag.
        put_frame(100, 200, 300, 400, 500, 2, 2, 3, 4, 5);
        wait_out(lat);
        if (CHK) check_outs("dup", 0, 100, 300, 400, 500, 1'b1);
        else     check_outs("dup", 0, 200, 300, 400, 500, 1'b0);
        handshake("dup");

        // Illegal tag.
        put_frame(9, 8, 7, 6, 5, 7, 2, 3, 4, 5);
        wait_out(lat);
        check_outs("ill", 0, 8, 7, 6, 5, CHK);
        handshake("ill");

        // Reset mid-frame, asserted at edge E+3.
        put_frame(11, 22, 33, 44, 55, 1, 2, 3, 4, 5);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_val("mrst_in_ready", 32'(in_ready), 32'd1);
        check_val("mrst_out_valid", 32'(out_valid), 32'd0);
        check_outs("mrst", 0, 0, 0, 0, 0, 1'b0);
        for (int k = 0; k < 6; k++) step();
        check_val("mrst_no_present", 32'(out_valid), 32'd0);
        put_frame(3, 6, 9, 12, 15, 3, 1, 5, 2, 4);
        wait_out(lat);
        check_val("fresh_latency", 32'(lat), 32'd5);
        check_outs("fresh", 6, 12, 3, 15, 9, 1'b0);
        handshake("fresh");

        // Back-to-back with out_ready held high.
        out_ready = 1'b1;
        s1 = 16'd1000; s2 = 16'd2000; s3 = 16'd3000; s4 = 16'd4000; s5 = 16'd5000;
        t1 = 3'd2; t2 = 3'd3; t3 = 3'd4; t4 = 3'd5; t5 = 3'd1;
        in_valid = 1'b1;
        step();
        s1 = 16'd7; s2 = 16'd8; s3 = 16'd9; s4 = 16'd10; s5 = 16'd11;
        t1 = 3'd5; t2 = 3'd1; t3 = 3'd2; t4 = 3'd3; t5 = 3'd4;
        gap = 0;
        seen_a = 1'b0;
        do begin
            step();
            gap++;
            if (out_valid && !seen_a) begin
                seen_a = 1'b1;
                check_val("b2b_a_latency", 32'(gap), 32'd5);
                check_outs("b2b_a", 5000, 1000, 2000, 3000, 4000, 1'b0);
            end
        end while (!in_ready && gap < 20);
        check_val("b2b_a_seen", 32'(seen_a), 32'd1);
        step();
        gap++;
        check_val("b2b_gap", 32'(gap), 32'd7);
        in_valid = 1'b0;
        s1 = 16'hdead; t1 = 3'd0;
        wait_out(lat);
        check_val("b2b_b_latency", 32'(lat), 32'd5);
        check_outs("b2b_b", 8, 9, 10, 11, 7, 1'b0);
        step();
        check_val("b2b_end_ov", 32'(out_valid), 32'd0);
        check_val("b2b_end_ir", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bubble_unsort.md
# bubble_unsort

Inverse-permutation stage for the 5-entry `bubble` sorter path: accepts a frame of five sorted words with 3-bit origin tags (original input slot 1..5) and scatters each word back to its original slot. It is sequential: one element per cycle, with valid/ready handshakes on both sides. It sits downstream of the sorter, after per-rank processing, and returns results in original input order.

## Interface
- DATA_W, 16, width of every data word
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  upstream frame valid
- in_ready  out  1  block can accept a frame
- s1..s5  in  DATA_W each  sorted words, s1 = smallest rank
- t1..t5  in  3 each  origin tag of s1..s5; legal values 1..5
- out1..out5  out  DATA_W each  words restored to original slot order
- out_valid  out  1  restored frame valid
- out_ready  in  1  downstream accepts frame
- err  out  1  frame tags were not a legal permutation; meaningful only while out_valid=1

## Operation
- FSM states: IDLE, SCATTER, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready:
  - capture s1..s5 and t1..t5 into internal registers;
  - clear out1..out5 and err to 0;
  - set index j=1;
  - go to SCATTER.
- SCATTER: in_ready=0. Each cycle, write captured s_j into out[t_j], then j=j+1. After the j=5 write, go to DONE.
- DONE: out_valid=1. On out_valid&&out_ready, go to IDLE. out1..out5 and err keep their values until the next accept.
- A new frame is never accepted while in SCATTER or DONE. There is no overlap between frames.
- Inputs s/t are sampled only at the accept edge. Later changes on s/t have no effect on the frame in progress.
- Data is moved unmodified. The block does no arithmetic on the data words.
- Illegal tag (0, 6 or 7): that element is not written.
- Duplicate tag handling depends on configuration (see Configuration).
- Any slot that receives no write reads 0.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, j=1;
  - in_ready=1, out_valid=0, err=0, out1..out5=0.
- Reset mid-SCATTER or mid-DONE aborts the frame. The partial frame is discarded and never presented.
- Latency: accept at edge E; writes at edges E+1..E+5; out_valid=1 after edge E+5.
- in_ready returns to 1 on the edge after the out handshake.
- Best-case throughput is one frame per 7 cycles, with out_ready held at 1.
- If out_ready=1 already when DONE is entered, the handshake completes on the very next edge.
- in_valid with in_ready=0 is ignored. Upstream must hold the frame until it is accepted.
- out_valid stays asserted until out_ready=1. There is no timeout.

## Configuration
- PERM_CHECK_EN defined:
  - a 5-bit seen mask is cleared at accept;
  - err is set (sticky for the frame) when a tag is out of range or its slot is already marked seen;
  - an element flagged this way is not written, so the first write to a slot wins;
  - err becomes visible together with out_valid.
- PERM_CHECK_EN undefined:
  - err is tied to 0 and no mask logic is built;
  - duplicate tags are last-write-wins (higher j overwrites);
  - out-of-range tags are still dropped.

## Test plan
- Identity permutation: s=10,20,30,40,50, t=1,2,3,4,5 -> out1..5=10,20,30,40,50, err=0, out_valid exactly 5 cycles after the accept edge.
- Reverse permutation: s=1,2,3,4,5, t=5,4,3,2,1 -> out1..5=5,4,3,2,1. With out_ready held low for 3 extra cycles, out1..5 stays stable and in_ready stays 0.
- Duplicate tag: s=100,200,300,400,500, t=2,2,3,4,5.
  - With PERM_CHECK_EN: out=0,100,300,400,500, err=1.
  - Without it: out=0,200,300,400,500, err=0.
- Illegal tag: t=7,2,3,4,5, s=9,8,7,6,5 -> out=0,8,7,6,5. err=1 only if PERM_CHECK_EN is defined.
- Reset mid-frame: drive rst_n=0 at cycle E+3 -> next cycle in_ready=1, out_valid=0, out1..5=0. A fresh frame then completes normally.
- Back-to-back frames with out_ready=1: in_valid held high with a new frame -> second accept occurs 7 cycles after the first. in_valid asserted during SCATTER/DONE is not accepted.
